// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised progressive raster timing generator
//
// Purpose
//    Walks a raster of H_TOTAL x V_TOTAL pixel positions, one position per
//    enabled pixel clock. From that walk it produces the sync pulses, the
//    current coordinates, the active-video flag, the line/frame/vblank event
//    strobes and a count of completed frames. Every output is a flop, and all
//    of them describe the same pixel: the one at the current hpos/vpos.
//
// Ports
//    clk           in   1     pixel clock
//    sys_rst       in   1     asynchronous reset, active-high
//    pix_en        in   1     pixel advance enable; 0 freezes every register
//    hsync         out  1     horizontal sync, asserted level H_SYNC_POL
//    vsync         out  1     vertical sync, asserted level V_SYNC_POL
//    hpos          out  CW    current column, 0..H_TOTAL-1
//    vpos          out  CW    current line, 0..V_TOTAL-1
//    active        out  1     hpos < H_VISIBLE and vpos < V_VISIBLE
//    line_start    out  1     entered column 0 of a line
//    frame_start   out  1     entered (0,0) by wrapping from the last pixel
//    vblank_start  out  1     entered (0,V_VISIBLE)
//    frame_cnt     out  FCW   completed frames, wraps modulo 2^FCW

module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FPORCH   = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BPORCH   = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FPORCH   = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BPORCH   = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int CW         = 10,
   parameter int FCW        = 8
) (
   input  logic           clk,
   input  logic           sys_rst,
   input  logic           pix_en,
   output logic           hsync,
   output logic           vsync,
   output logic [CW-1:0]  hpos,
   output logic [CW-1:0]  vpos,
   output logic           active,
   output logic           line_start,
   output logic           frame_start,
   output logic           vblank_start,
   output logic [FCW-1:0] frame_cnt
);

   localparam int H_TOTAL  = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
   localparam int V_TOTAL  = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;
   localparam int HS_START = H_VISIBLE + H_FPORCH;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FPORCH;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);

   // Range bounds carry one extra bit: a sync pulse that runs to the very
   // end of the line/frame has an exclusive end equal to TOTAL, which may
   // not fit in CW bits.
   localparam logic [CW:0] H_VIS_W    = (CW+1)'(H_VISIBLE);
   localparam logic [CW:0] V_VIS_W    = (CW+1)'(V_VISIBLE);
   localparam logic [CW:0] HS_START_W = (CW+1)'(HS_START);
   localparam logic [CW:0] HS_END_W   = (CW+1)'(HS_END);
   localparam logic [CW:0] VS_START_W = (CW+1)'(VS_START);
   localparam logic [CW:0] VS_END_W   = (CW+1)'(VS_END);

   localparam logic HS_ON = 1'(H_SYNC_POL);
   localparam logic VS_ON = 1'(V_SYNC_POL);

   logic [CW-1:0]  hpos_q, hpos_d;
   logic [CW-1:0]  vpos_q, vpos_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           active_q, active_d;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;
   logic           vblank_start_q, vblank_start_d;

   logic           h_last;
   logic           v_last;
   logic [CW:0]    hpos_w;
   logic [CW:0]    vpos_w;

   assign h_last = (hpos_q == H_LAST);
   assign v_last = (vpos_q == V_LAST);

   always_comb begin
      hpos_d         = hpos_q;
      vpos_d         = vpos_q;
      frame_cnt_d    = frame_cnt_q;
      hsync_d        = hsync_q;
      vsync_d        = vsync_q;
      active_d       = active_q;
      line_start_d   = line_start_q;
      frame_start_d  = frame_start_q;
      vblank_start_d = vblank_start_q;
      hpos_w         = '0;
      vpos_w         = '0;

      // With pix_en low nothing moves, strobes included, so a consumer that
      // qualifies a strobe with pix_en sees each event exactly once.
      if (pix_en) begin
         if (h_last) begin
            hpos_d = '0;
            if (v_last) begin
               vpos_d      = '0;
               frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
               vpos_d = vpos_q + 1'b1;
            end
         end else begin
            hpos_d = hpos_q + 1'b1;
         end

         // Every flag is derived from the coordinates being loaded, so the
         // flags land in the same cycle as the position they describe.
         hpos_w = {1'b0, hpos_d};
         vpos_w = {1'b0, vpos_d};

         hsync_d  = (hpos_w >= HS_START_W && hpos_w < HS_END_W) ? HS_ON : ~HS_ON;
         vsync_d  = (vpos_w >= VS_START_W && vpos_w < VS_END_W) ? VS_ON : ~VS_ON;
         active_d = (hpos_w < H_VIS_W) && (vpos_w < V_VIS_W);

         // Column 0 is only ever loaded by a wrap, so these compares fire
         // once per event and never straight out of reset.
         line_start_d   = (hpos_d == '0);
         frame_start_d  = (hpos_d == '0) && (vpos_d == '0);
         vblank_start_d = (hpos_d == '0) && (vpos_d == V_VIS);
      end
   end

   // Asynchronous reset drops straight back to the (0,0) state with sync
   // deasserted, so a reset in the middle of a pulse cuts it short.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         hpos_q         <= '0;
         vpos_q         <= '0;
         frame_cnt_q    <= '0;
         hsync_q        <= ~HS_ON;
         vsync_q        <= ~VS_ON;
         active_q       <= 1'b1;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
      end else begin
         hpos_q         <= hpos_d;
         vpos_q         <= vpos_d;
         frame_cnt_q    <= frame_cnt_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         active_q       <= active_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
      end
   end

   assign hpos         = hpos_q;
   assign vpos         = vpos_q;
   assign frame_cnt    = frame_cnt_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign active       = active_q;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
//
// Purpose
//    Drives two instances of vga_timing_gen with small rasters:
//    u_dut: 16x10 raster (10+2+3+1 / 6+1+2+1), active-low syncs, 3-bit frame count.
//    u_pol: 5x3 raster with zero porches and active-high syncs.
//
// Ports
//    none (top-level bench)

module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       pix_en;
   logic       hsync, vsync, active, line_start, frame_start, vblank_start;
   logic [4:0] hpos, vpos;
   logic [2:0] frame_cnt;

   logic       pol_rst;
   logic       pol_en;
   logic       p_hsync, p_vsync, p_active, p_line_start, p_frame_start, p_vblank_start;
   logic [2:0] p_hpos, p_vpos;
   logic [1:0] p_frame_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int eh, ev, efc;
   int hs_low, vs_low;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_VISIBLE(10), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(1),
      .V_VISIBLE(6),  .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .CW(5), .FCW(3)
   ) u_dut (
      .clk(clk), .sys_rst(sys_rst), .pix_en(pix_en),
      .hsync(hsync), .vsync(vsync), .hpos(hpos), .vpos(vpos),
      .active(active), .line_start(line_start), .frame_start(frame_start),
      .vblank_start(vblank_start), .frame_cnt(frame_cnt)
   );

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FPORCH(0), .H_SYNC(1), .H_BPORCH(0),
      .V_VISIBLE(2), .V_FPORCH(0), .V_SYNC(1), .V_BPORCH(0),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .CW(3), .FCW(2)
   ) u_pol (
      .clk(clk), .sys_rst(pol_rst), .pix_en(pol_en),
      .hsync(p_hsync), .vsync(p_vsync), .hpos(p_hpos), .vpos(p_vpos),
      .active(p_active), .line_start(p_line_start), .frame_start(p_frame_start),
      .vblank_start(p_vblank_start), .frame_cnt(p_frame_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " hpos"},         32'(hpos),         32'd0);
      chk({tag, " vpos"},         32'(vpos),         32'd0);
      chk({tag, " hsync"},        32'(hsync),        32'd1);
      chk({tag, " vsync"},        32'(vsync),        32'd1);
      chk({tag, " active"},       32'(active),       32'd1);
      chk({tag, " line_start"},   32'(line_start),   32'd0);
      chk({tag, " frame_start"},  32'(frame_start),  32'd0);
      chk({tag, " vblank_start"}, 32'(vblank_start), 32'd0);
      chk({tag, " frame_cnt"},    32'(frame_cnt),    32'd0);
   endtask

   initial begin
      sys_rst = 1'b1;
      pix_en  = 1'b0;
      pol_rst = 1'b1;
      pol_en  = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values of both instances
      chk_reset_state("rst");
      chk("pol rst hsync",  32'(p_hsync),  32'd0);
      chk("pol rst vsync",  32'(p_vsync),  32'd0);
      chk("pol rst active", 32'(p_active), 32'd1);
      chk("pol rst hpos",   32'(p_hpos),   32'd0);

      // Out of reset with pix_en low: nothing moves, no strobe appears
      sys_rst = 1'b0;
      @(negedge clk);
      chk("idle hpos",       32'(hpos),       32'd0);
      chk("idle line_start", 32'(line_start), 32'd0);

      // Two full frames plus five pixels against an independent position model
      pix_en = 1'b1;
      eh = 0; ev = 0; efc = 0; hs_low = 0; vs_low = 0;
      for (int c = 1; c <= 325; c++) begin
         @(negedge clk);
         if (eh == 15) begin
            eh = 0;
            if (ev == 9) begin
               ev  = 0;
               efc = (efc + 1) % 8;
            end else begin
               ev++;
            end
         end else begin
            eh++;
         end
         chk($sformatf("run hpos c%0d", c),   32'(hpos), 32'(eh));
         chk($sformatf("run vpos c%0d", c),   32'(vpos), 32'(ev));
         chk($sformatf("run hsync c%0d", c),  32'(hsync),  (eh >= 12 && eh < 15) ? 32'd0 : 32'd1);
         chk($sformatf("run vsync c%0d", c),  32'(vsync),  (ev >= 7 && ev < 9) ? 32'd0 : 32'd1);
         chk($sformatf("run active c%0d", c), 32'(active), (eh < 10 && ev < 6) ? 32'd1 : 32'd0);
         chk($sformatf("run line_start c%0d", c),   32'(line_start),   (eh == 0) ? 32'd1 : 32'd0);
         chk($sformatf("run frame_start c%0d", c),  32'(frame_start),  (eh == 0 && ev == 0) ? 32'd1 : 32'd0);
         chk($sformatf("run vblank_start c%0d", c), 32'(vblank_start), (eh == 0 && ev == 6) ? 32'd1 : 32'd0);
         chk($sformatf("run frame_cnt c%0d", c),    32'(frame_cnt),    32'(efc));
         if (c <= 160) begin
            if (hsync == 1'b0) hs_low++;
            if (vsync == 1'b0) vs_low++;
         end
      end
      // 10 lines x 3 sync pixels; 2 sync lines x 16 pixels
      chk("hsync low per frame", 32'(hs_low), 32'd30);
      chk("vsync low per frame", 32'(vs_low), 32'd32);
      chk("after run hpos",      32'(hpos),      32'd5);
      chk("after run frame_cnt", 32'(frame_cnt), 32'd2);

      // Advance from (5,0) into both sync pulses at (13,7)
      repeat (120) @(negedge clk);
      chk("pre-rst hpos",  32'(hpos),  32'd13);
      chk("pre-rst vpos",  32'(vpos),  32'd7);
      chk("pre-rst hsync", 32'(hsync), 32'd0);
      chk("pre-rst vsync", 32'(vsync), 32'd0);

      // Asynchronous reset between clock edges takes effect at once
      #2 sys_rst = 1'b1;
      #1 chk_reset_state("async rst");
      @(negedge clk);
      chk("rst held hpos", 32'(hpos), 32'd0);
      sys_rst = 1'b0;
      @(negedge clk);
      chk("restart hpos",       32'(hpos),       32'd1);
      chk("restart vpos",       32'(vpos),       32'd0);
      chk("restart line_start", 32'(line_start), 32'd0);
      repeat (10) @(negedge clk);
      chk("restart hpos 11",  32'(hpos),  32'd11);
      chk("restart hsync 11", 32'(hsync), 32'd1);
      @(negedge clk);
      chk("restart hsync 12",    32'(hsync),     32'd0);
      chk("restart frame_cnt",   32'(frame_cnt), 32'd0);

      // From (12,0) to the last pixel of the eighth frame, then the wrap
      repeat (1267) @(negedge clk);
      chk("last px hpos",      32'(hpos),      32'd15);
      chk("last px vpos",      32'(vpos),      32'd9);
      chk("last px frame_cnt", 32'(frame_cnt), 32'd7);
      @(negedge clk);
      chk("wrap hpos",         32'(hpos),         32'd0);
      chk("wrap vpos",         32'(vpos),         32'd0);
      chk("wrap frame_cnt",    32'(frame_cnt),    32'd0);
      chk("wrap frame_start",  32'(frame_start),  32'd1);
      chk("wrap line_start",   32'(line_start),   32'd1);
      chk("wrap vblank_start", 32'(vblank_start), 32'd0);

      // Enable gap right on the frame strobe: everything held
      pix_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("gap hpos %0d", i),        32'(hpos),        32'd0);
         chk($sformatf("gap frame_start %0d", i), 32'(frame_start), 32'd1);
         chk($sformatf("gap line_start %0d", i),  32'(line_start),  32'd1);
         chk($sformatf("gap frame_cnt %0d", i),   32'(frame_cnt),   32'd0);
      end
      pix_en = 1'b1;
      @(negedge clk);
      chk("post-gap hpos",        32'(hpos),        32'd1);
      chk("post-gap frame_start", 32'(frame_start), 32'd0);
      chk("post-gap frame_cnt",   32'(frame_cnt),   32'd0);

      // pix_en 1,0,0,1 from hpos 5 -> 6,6,6,7
      repeat (4) @(negedge clk);
      chk("en seq hpos 5", 32'(hpos), 32'd5);
      @(negedge clk);
      chk("en seq hpos 6a", 32'(hpos), 32'd6);
      pix_en = 1'b0;
      @(negedge clk);
      chk("en seq hpos 6b", 32'(hpos), 32'd6);
      @(negedge clk);
      chk("en seq hpos 6c", 32'(hpos), 32'd6);
      pix_en = 1'b1;
      @(negedge clk);
      chk("en seq hpos 7", 32'(hpos), 32'd7);

      // Zero-porch raster with active-high syncs, two frames
      pol_rst = 1'b0;
      pol_en  = 1'b1;
      eh = 0; ev = 0; efc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (eh == 4) begin
            eh = 0;
            if (ev == 2) begin
               ev  = 0;
               efc = (efc + 1) % 4;
            end else begin
               ev++;
            end
         end else begin
            eh++;
         end
         chk($sformatf("pol hpos c%0d", c),   32'(p_hpos),   32'(eh));
         chk($sformatf("pol vpos c%0d", c),   32'(p_vpos),   32'(ev));
         chk($sformatf("pol hsync c%0d", c),  32'(p_hsync),  (eh == 4) ? 32'd1 : 32'd0);
         chk($sformatf("pol vsync c%0d", c),  32'(p_vsync),  (ev == 2) ? 32'd1 : 32'd0);
         chk($sformatf("pol active c%0d", c), 32'(p_active), (eh < 4 && ev < 2) ? 32'd1 : 32'd0);
         chk($sformatf("pol line_start c%0d", c),   32'(p_line_start),   (eh == 0) ? 32'd1 : 32'd0);
         chk($sformatf("pol frame_start c%0d", c),  32'(p_frame_start),  (eh == 0 && ev == 0) ? 32'd1 : 32'd0);
         chk($sformatf("pol vblank_start c%0d", c), 32'(p_vblank_start), (eh == 0 && ev == 2) ? 32'd1 : 32'd0);
         chk($sformatf("pol frame_cnt c%0d", c),    32'(p_frame_cnt),    32'(efc));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
